fp_div_pipe: RTL and testbench
==============================

Name: fp_div_pipe

Overview:
- Fully pipelined fixed-point divider with one-result-per-cycle throughput; successor to the team's iterative fixed-point divider.
- Returns floor(dividend·2^FRAC_BITS / divisor) with a configurable quotient integer width and per-transaction signed/unsigned mode.
- Overflow and divide-by-zero saturate the result. A tag travels with each operand pair.
- Sits between autocorrelation/normalisation logic and the pitch estimator, which consume a stream of ratios.

Parameters:
IN_WIDTH, 16, width of dividend and divisor (two's complement when signed_in=1).
FRAC_BITS, 10, fractional bits in the quotient.
QINT_BITS, 2, integer bits in the quotient (≥1); Q = QINT_BITS+FRAC_BITS.
BITS_PER_STAGE, 2, quotient bits resolved per working stage.
TAG_WIDTH, 4, sideband tag width (≥1).

Ports:
clk_in  input  1  clock.
rst_in  input  1  synchronous active-high reset.
dividend_in  input  IN_WIDTH  dividend.
divisor_in  input  IN_WIDTH  divisor.
signed_in  input  1  1 = operands and result are two's complement.
tag_in  input  TAG_WIDTH  sideband, returned unchanged.
valid_in  input  1  operands valid.
ready_out  output  1  accepting; transfer when valid_in && ready_out.
quotient_out  output  Q  result (two's complement when signed).
err_out  output  1  divide-by-zero flag for this result.
sat_out  output  1  result was saturated (overflow or divide-by-zero).
tag_out  output  TAG_WIDTH  tag of this result.
valid_out  output  1  result valid.
ready_in  input  1  downstream accepts; transfer when valid_out && ready_in.

Behaviour:
- One clock (clk_in); reset is synchronous and active-high (rst_in).
- Stage structure: S = ceil((Q+G)/BITS_PER_STAGE) working stages, plus an input register stage and an output register stage. G = 0 by default.
- Latency from accepted input to valid_out is S+2 cycles when no stall occurs. Default S = 6, so latency = 8.
- Input stage:
  - Takes magnitudes when signed_in.
  - Result sign = sign(dividend) XOR sign(divisor).
  - Flags divzero (divisor == 0).
  - Flags overflow when |D| ≥ |d|·2^QINT_BITS (unsigned) or |D| ≥ |d|·2^(QINT_BITS-1) (signed). Internal compare is widened so no bits are lost.
- Working stages: restoring long division, BITS_PER_STAGE bits per stage, MSB first. Each stage register carries partial remainder, divisor, partial quotient, sign, flags, tag and a valid bit.
- Output stage:
  - Unsigned result = magnitude.
  - Signed result = magnitude negated when the result sign is negative (truncation toward zero).
- Saturation:
  - Unsigned overflow → all ones.
  - Signed overflow → 2^(Q-1)-1 if positive, -2^(Q-1) if negative.
  - Divide-by-zero → err_out=1, sat_out=1. Unsigned result = all ones. Signed result = 2^(Q-1)-1 if dividend ≥ 0, otherwise -2^(Q-1).
- Flow control:
  - stall = valid_out && !ready_in; ready_out = !stall.
  - On stall every stage holds. Otherwise all stages advance, and empty slots advance as bubbles (valid bit 0).
  - Results leave in acceptance order, never dropped or duplicated.
  - valid_in while ready_out = 0 is ignored; upstream holds its operands.
- Reset (also mid-flight): all valid bits cleared. valid_out=0, quotient_out=0, err_out=0, sat_out=0, tag_out=0. In-flight transactions are discarded. ready_out=1 on the cycle after reset deasserts.
- Outputs are stable while valid_out && !ready_in.

Optional Feature:
- Macro FP_DIV_PIPE_ROUND_EN.
- Defined:
  - G = 1: one extra guard bit is computed, and latency rises per the formula above when it crosses a stage boundary.
  - Magnitude is rounded half-up using the guard bit before sign application.
  - If rounding carries past the representable range, the result saturates and sat_out=1.
- Undefined: G = 0, truncation only, no extra logic.

Test Plan:
- Unsigned 3/2, tag 5 → quotient_out 0x600, err 0, sat 0, tag_out 5, valid_out exactly 8 cycles after the accepting edge.
- Unsigned 100/3 → 0xFFF, sat 1, err 0. Signed -8/2 (0xFFF8 / 0x0002) → 0x800, sat 1.
- Signed -3/2 (0xFFFD / 0x0002) → 0xA00 (-1536). Signed 3/-2 → 0xA00. Signed -3/-2 → 0x600.
- Divide-by-zero:
  - Unsigned 5/0 → 0xFFF, err 1, sat 1.
  - Signed -5/0 → 0x800, err 1.
  - The following transaction 1/1 → 0x400 with err 0.
- Stream of 12 back-to-back inputs, tags 0..11, with ready_in low for 3 cycles mid-stream → ready_out low exactly during the stall, outputs in tag order, no loss or duplication, values match the floor model.
- rst_in asserted for 1 cycle with 4 transactions in flight → no valid_out for those; a new 2/1 sent after reset returns 0x800 at latency 8. With FP_DIV_PIPE_ROUND_EN, unsigned 2/3 → 683 (682 without the macro).

Source files
------------

// File: rtl/fp_div_pipe_if.sv
// Operand/result stream bundle for fp_div_pipe.
// Master drives operands and downstream ready; slave is the divider.
interface fp_div_pipe_if #(
  parameter int IN_WIDTH  = 16,
  parameter int Q_WIDTH   = 12,
  parameter int TAG_WIDTH = 4
);
  logic [IN_WIDTH-1:0]  dividend_in;
  logic [IN_WIDTH-1:0]  divisor_in;
  logic                 signed_in;
  logic [TAG_WIDTH-1:0] tag_in;
  logic                 valid_in;
  logic                 ready_out;
  logic [Q_WIDTH-1:0]   quotient_out;
  logic                 err_out;
  logic                 sat_out;
  logic [TAG_WIDTH-1:0] tag_out;
  logic                 valid_out;
  logic                 ready_in;

  modport master (
    output dividend_in, divisor_in, signed_in, tag_in, valid_in, ready_in,
    input  ready_out, quotient_out, err_out, sat_out, tag_out, valid_out
  );

  modport slave (
    input  dividend_in, divisor_in, signed_in, tag_in, valid_in, ready_in,
    output ready_out, quotient_out, err_out, sat_out, tag_out, valid_out
  );
endinterface

// File: rtl/fp_div_pipe.sv
// Fully pipelined restoring fixed-point divider, one result per cycle, saturating.
// Define FP_DIV_PIPE_ROUND_EN for a guard bit and round-half-up of the magnitude.
module fp_div_pipe #(
  parameter int IN_WIDTH       = 16,
  parameter int FRAC_BITS      = 10,
  parameter int QINT_BITS      = 2,
  parameter int BITS_PER_STAGE = 2,
  parameter int TAG_WIDTH      = 4
) (
  input logic          clk_in,
  input logic          rst_in,
  fp_div_pipe_if.slave bus
);
  localparam int Q = QINT_BITS + FRAC_BITS;
`ifdef FP_DIV_PIPE_ROUND_EN
  localparam int G = 1;
`else
  localparam int G = 0;
`endif
  localparam int S  = (Q + G + BITS_PER_STAGE - 1) / BITS_PER_STAGE;
  localparam int QW = S * BITS_PER_STAGE;
  localparam int NW = IN_WIDTH + QW;
  localparam int CW = IN_WIDTH + QINT_BITS;

  localparam logic [Q-1:0] QMAX = {1'b0, {(Q-1){1'b1}}};
  localparam logic [Q-1:0] QMIN = {1'b1, {(Q-1){1'b0}}};

  typedef struct packed {
    logic                 valid;
    logic [IN_WIDTH-1:0]  dividend;
    logic [IN_WIDTH-1:0]  divisor;
    logic                 sgn;
    logic [TAG_WIDTH-1:0] tag;
  } in_t;

  typedef struct packed {
    logic                 valid;
    logic [IN_WIDTH-1:0]  rem;
    logic [QW-1:0]        num;
    logic [IN_WIDTH-1:0]  dvs;
    logic [QW-1:0]        quo;
    logic                 sgn;
    logic                 neg;
    logic                 ovf;
    logic                 dz;
    logic                 dneg;
    logic [TAG_WIDTH-1:0] tag;
  } work_t;

  typedef struct packed {
    logic                 valid;
    logic [Q-1:0]         quo;
    logic                 err;
    logic                 sat;
    logic [TAG_WIDTH-1:0] tag;
  } out_t;

  // Resolves BITS_PER_STAGE quotient bits, MSB first; remainder stays below the divisor.
  function automatic work_t div_step(input work_t w);
    work_t             r;
    logic [IN_WIDTH:0] trial;
    r = w;
    for (int b = 0; b < BITS_PER_STAGE; b++) begin
      trial = {r.rem, r.num[QW-1]};
      r.num = r.num << 1;
      if (trial >= {1'b0, r.dvs}) begin
        trial = trial - {1'b0, r.dvs};
        r.quo = {r.quo[QW-2:0], 1'b1};
      end else begin
        r.quo = {r.quo[QW-2:0], 1'b0};
      end
      r.rem = trial[IN_WIDTH-1:0];
    end
    return r;
  endfunction

  in_t   in_q;
  work_t work_q [0:S];
  work_t work_d [1:S];
  work_t cond_d;
  out_t  out_q;
  out_t  out_d;

  logic                stall_s;
  logic                a_neg_s;
  logic                b_neg_s;
  logic [IN_WIDTH-1:0] mag_a_s;
  logic [IN_WIDTH-1:0] mag_b_s;
  logic [CW-1:0]       cmp_lhs_s;
  logic [CW-1:0]       cmp_rhs_s;
  logic [NW-1:0]       num_full_s;
  logic [Q-1:0]        mag_s;
  logic                rng_ovf_s;
  logic                unused_last_s;

  assign stall_s       = out_q.valid & ~bus.ready_in;
  assign bus.ready_out = ~stall_s;

  assign a_neg_s = in_q.sgn & in_q.dividend[IN_WIDTH-1];
  assign b_neg_s = in_q.sgn & in_q.divisor[IN_WIDTH-1];
  assign mag_a_s = a_neg_s ? (~in_q.dividend + IN_WIDTH'(1)) : in_q.dividend;
  assign mag_b_s = b_neg_s ? (~in_q.divisor + IN_WIDTH'(1)) : in_q.divisor;

  // Operand conditioning: magnitudes, sign, widened overflow compare, initial remainder.
  always_comb begin
    cond_d     = '0;
    cmp_lhs_s  = CW'(mag_a_s);
    cmp_rhs_s  = CW'(mag_b_s) << (in_q.sgn ? (QINT_BITS - 1) : QINT_BITS);
    num_full_s = NW'(mag_a_s) << (FRAC_BITS + G);
    cond_d.valid = in_q.valid;
    cond_d.rem   = num_full_s[NW-1:QW];
    cond_d.num   = num_full_s[QW-1:0];
    cond_d.dvs   = mag_b_s;
    cond_d.sgn   = in_q.sgn;
    cond_d.neg   = a_neg_s ^ b_neg_s;
    cond_d.ovf   = (cmp_lhs_s >= cmp_rhs_s);
    cond_d.dz    = (in_q.divisor == '0);
    cond_d.dneg  = a_neg_s;
    cond_d.tag   = in_q.tag;
  end

  // Long-division ranks.
  always_comb begin
    work_d = '{default: '0};
    for (int k = 1; k <= S; k++) begin
      work_d[k] = div_step(work_q[k-1]);
    end
  end

`ifdef FP_DIV_PIPE_ROUND_EN
  localparam logic [Q:0] HALF = {2'b01, {(Q-1){1'b0}}};
  logic [Q:0] rnd_s;
  assign rnd_s     = {1'b0, work_q[S].quo[Q:1]} + (Q+1)'(work_q[S].quo[0]);
  assign mag_s     = rnd_s[Q-1:0];
  assign rng_ovf_s = !work_q[S].sgn ? rnd_s[Q] :
                     (work_q[S].neg ? (rnd_s > HALF) : (rnd_s >= HALF));
`else
  assign mag_s     = work_q[S].quo[Q-1:0];
  assign rng_ovf_s = 1'b0;
`endif

  assign unused_last_s = ^{work_q[S].rem, work_q[S].num, work_q[S].dvs, work_q[S].quo};

  // Sign application and saturation; divide-by-zero takes priority over overflow.
  always_comb begin
    out_d       = '0;
    out_d.valid = work_q[S].valid;
    out_d.tag   = work_q[S].tag;
    if (work_q[S].dz) begin
      out_d.err = 1'b1;
      out_d.sat = 1'b1;
      out_d.quo = !work_q[S].sgn ? {Q{1'b1}} : (work_q[S].dneg ? QMIN : QMAX);
    end else if (work_q[S].ovf || rng_ovf_s) begin
      out_d.sat = 1'b1;
      out_d.quo = !work_q[S].sgn ? {Q{1'b1}} : (work_q[S].neg ? QMIN : QMAX);
    end else if (work_q[S].neg) begin
      out_d.quo = ~mag_s + Q'(1);
    end else begin
      out_d.quo = mag_s;
    end
  end

  // Whole pipeline advances in lockstep; a held output freezes every rank.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      in_q   <= '0;
      work_q <= '{default: '0};
      out_q  <= '0;
    end else if (!stall_s) begin
      in_q.valid    <= bus.valid_in;
      in_q.dividend <= bus.dividend_in;
      in_q.divisor  <= bus.divisor_in;
      in_q.sgn      <= bus.signed_in;
      in_q.tag      <= bus.tag_in;
      work_q[0]     <= cond_d;
      for (int k = 1; k <= S; k++) begin
        work_q[k] <= work_d[k];
      end
      out_q <= out_d;
    end
  end

  assign bus.valid_out    = out_q.valid;
  assign bus.quotient_out = out_q.quo;
  assign bus.err_out      = out_q.err;
  assign bus.sat_out      = out_q.sat;
  assign bus.tag_out      = out_q.tag;
endmodule

// File: tb/tb_fp_div_pipe.sv
// Scoreboard bench for fp_div_pipe: driver pushes expected results, negedge monitor pops and compares.
module tb_fp_div_pipe;
`ifdef FP_DIV_PIPE_ROUND_EN
  localparam int            G   = 1;
  localparam logic [11:0]   Q23 = 12'd683;
`else
  localparam int            G   = 0;
  localparam logic [11:0]   Q23 = 12'd682;
`endif
  localparam int LAT = (12 + G + 1) / 2 + 2;

  typedef struct {
    logic [11:0] q;
    logic        err;
    logic        sat;
    logic [3:0]  tag;
    bit          lat;
    int          acc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb [$];
  exp_t mon_e;

  fp_div_pipe_if #(.IN_WIDTH(16), .Q_WIDTH(12), .TAG_WIDTH(4)) bus ();

  fp_div_pipe dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // Monitor: every transferred result must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.valid_out && bus.ready_in) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("quotient", 32'(bus.quotient_out), 32'(mon_e.q));
        chk("err", 32'(bus.err_out), 32'(mon_e.err));
        chk("sat", 32'(bus.sat_out), 32'(mon_e.sat));
        chk("tag", 32'(bus.tag_out), 32'(mon_e.tag));
        if (mon_e.lat) chk("latency", 32'(cyc - mon_e.acc), 32'(LAT));
      end
    end
  end

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic sg,
                      input logic [3:0] tg, input logic [11:0] eq, input logic ee,
                      input logic es, input bit lat);
    exp_t e;
    bit   done = 1'b0;
    bus.dividend_in = a;
    bus.divisor_in  = b;
    bus.signed_in   = sg;
    bus.tag_in      = tg;
    bus.valid_in    = 1'b1;
    for (int g = 0; g < 60 && !done; g++) begin
      @(negedge clk);
      if (bus.ready_out) begin
        e.q = eq; e.err = ee; e.sat = es; e.tag = tg; e.lat = lat; e.acc = cyc + 1;
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    bus.valid_in = 1'b0;
    if (!done) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain(input int max);
    int g = 0;
    while (sb.size() != 0 && g < max) begin
      @(negedge clk);
      g++;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  logic [15:0] sa [12] = '{16'd1, 16'd3, 16'd5, 16'd1, 16'd7, 16'd3,
                           16'd0, 16'd9, 16'd100, 16'd1000, 16'd255, 16'd11};
  logic [15:0] sdv [12] = '{16'd1, 16'd4, 16'd8, 16'd3, 16'd2, 16'd5,
                            16'd5, 16'd3, 16'd30, 16'd999, 16'd256, 16'd7};
  logic [11:0] sq [12] = '{12'h400, 12'h300, 12'h280, 12'h155, 12'hE00, 12'h266,
                           12'h000, 12'hC00, 12'hD55, 12'h401, 12'h3FC, 12'h649};

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] held_q;
    logic [3:0]  held_t;
    rst = 1'b1;
    bus.valid_in = 1'b0; bus.ready_in = 1'b1; bus.signed_in = 1'b0;
    bus.dividend_in = '0; bus.divisor_in = '0; bus.tag_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ready_out", 32'(bus.ready_out), 32'd1);
    chk("reset_valid_out", 32'(bus.valid_out), 32'd0);
    chk("reset_quotient", 32'(bus.quotient_out), 32'd0);
    chk("reset_err_sat", 32'({bus.err_out, bus.sat_out}), 32'd0);
    chk("reset_tag", 32'(bus.tag_out), 32'd0);
    @(posedge clk); #1;

    // Directed single transactions, each drained to check latency.
    send(16'd3, 16'd2, 1'b0, 4'd5, 12'h600, 1'b0, 1'b0, 1'b1);       drain(40);
    send(16'd100, 16'd3, 1'b0, 4'd1, 12'hFFF, 1'b0, 1'b1, 1'b1);     drain(40);
    send(16'hFFF8, 16'h0002, 1'b1, 4'd2, 12'h800, 1'b0, 1'b1, 1'b1); drain(40);
    send(16'hFFFD, 16'h0002, 1'b1, 4'd3, 12'hA00, 1'b0, 1'b0, 1'b1); drain(40);
    send(16'h0003, 16'hFFFE, 1'b1, 4'd4, 12'hA00, 1'b0, 1'b0, 1'b1); drain(40);
    send(16'hFFFD, 16'hFFFE, 1'b1, 4'd6, 12'h600, 1'b0, 1'b0, 1'b1); drain(40);
    send(16'd5, 16'd0, 1'b0, 4'd7, 12'hFFF, 1'b1, 1'b1, 1'b1);       drain(40);
    send(16'hFFFB, 16'd0, 1'b1, 4'd8, 12'h800, 1'b1, 1'b1, 1'b1);    drain(40);
    send(16'd1, 16'd1, 1'b0, 4'd9, 12'h400, 1'b0, 1'b0, 1'b1);       drain(40);
    send(16'd2, 16'd3, 1'b0, 4'd10, Q23, 1'b0, 1'b0, 1'b1);          drain(40);

    // Back-to-back stream with a 3-cycle downstream stall in the middle.
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          send(sa[i], sdv[i], 1'b0, 4'(i), sq[i], 1'b0, 1'b0, 1'b0);
        end
      end
      begin
        for (int g = 0; g < 40 && !bus.valid_out; g++) @(negedge clk);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.ready_in = 1'b0;
        @(negedge clk);
        chk("stall_ready_out", 32'(bus.ready_out), 32'd0);
        chk("stall_valid_out", 32'(bus.valid_out), 32'd1);
        held_q = bus.quotient_out;
        held_t = bus.tag_out;
        repeat (2) begin
          @(negedge clk);
          chk("stall_ready_out", 32'(bus.ready_out), 32'd0);
          chk("stall_hold_quotient", 32'(bus.quotient_out), 32'(held_q));
          chk("stall_hold_tag", 32'(bus.tag_out), 32'(held_t));
        end
        @(posedge clk); #1;
        bus.ready_in = 1'b1;
        @(negedge clk);
        chk("unstall_ready_out", 32'(bus.ready_out), 32'd1);
        @(posedge clk); #1;
      end
    join
    drain(60);

    // Reset with four transactions in flight: none may emerge.
    for (int i = 0; i < 4; i++) begin
      send(16'd1, 16'd1, 1'b0, 4'(12 + i), 12'h400, 1'b0, 1'b0, 1'b0);
    end
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midreset_ready_out", 32'(bus.ready_out), 32'd1);
    chk("midreset_quotient", 32'(bus.quotient_out), 32'd0);
    chk("midreset_flags_tag", 32'({bus.err_out, bus.sat_out, bus.tag_out}), 32'd0);
    repeat (12) begin
      @(negedge clk);
      chk("post_reset_no_valid", 32'(bus.valid_out), 32'd0);
    end
    @(posedge clk); #1;
    send(16'd2, 16'd1, 1'b0, 4'd11, 12'h800, 1'b0, 1'b0, 1'b1);
    drain(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
